// File: rtl/key_entry_decode_if.sv
// Key-entry bus: key pulses into the decoder, display/entry state back out.
// The master drives key_pulse; the slave (the decoder) drives everything else.
interface key_entry_decode_if #(
    parameter int NUM_KEYS = 16,
    parameter int DIGITS   = 4
);
    logic [NUM_KEYS-1:0]  key_pulse;
    logic [4*DIGITS-1:0]  seg_data;
    logic [3:0]           digit_cnt;
    logic [4:0]           key_code;
    logic                 key_valid;
    logic                 multi_err;
    logic                 enter_pulse;
    logic [4*DIGITS-1:0]  entry_value;

    modport master (
        output key_pulse,
        input  seg_data, digit_cnt, key_code, key_valid,
        input  multi_err, enter_pulse, entry_value
    );

    modport slave (
        input  key_pulse,
        output seg_data, digit_cnt, key_code, key_valid,
        output multi_err, enter_pulse, entry_value
    );
endinterface

// File: rtl/key_entry_decode.sv
// Keypad pulse decoder: shows the last key as BCD (MODE 0) or builds a
// multi-digit BCD entry with backspace/clear/enter editing (MODE 1).
module key_entry_decode #(
    parameter int NUM_KEYS = 16,
    parameter int DIGITS   = 4,
    parameter int MODE     = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    key_entry_decode_if.slave  bus
);
    localparam int SEG_W = 4 * DIGITS;

    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_PARTIAL = 2'd1;
    localparam logic [1:0] ST_FULL    = 2'd2;

    localparam logic [4:0] KEY_ZERO  = 5'd10;
    localparam logic [4:0] KEY_BKSP  = 5'd11;
    localparam logic [4:0] KEY_CLEAR = 5'd12;
    localparam logic [4:0] KEY_ENTER = 5'd13;

    logic [1:0]       state_q,  state_d;
    logic [SEG_W-1:0] seg_q,    seg_d;
    logic [SEG_W-1:0] entry_q,  entry_d;
    logic [3:0]       cnt_q,    cnt_d;
    logic [4:0]       code_q,   code_d;
    logic             valid_q,  valid_d;
    logic             err_q,    err_d;
    logic             enter_q,  enter_d;

    logic [4:0] code;
    logic [3:0] digit;
    logic [7:0] bcd;
    logic       is_single;
    logic       is_multi;

    // Priority order is irrelevant: the code is only used when exactly one bit is set.
    always_comb begin
        code = 5'd0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (bus.key_pulse[i]) code = 5'(i + 1);
        end
    end

    assign is_single = ($countones(bus.key_pulse) == 1);
    assign is_multi  = ($countones(bus.key_pulse) > 1);
    assign digit     = (code == KEY_ZERO) ? 4'd0 : code[3:0];
    assign bcd       = (code >= 5'd10) ? {4'h1, 4'(code - 5'd10)} : {4'h0, code[3:0]};

    always_comb begin
        // NOTE: every register input gets its hold value first so no path infers a latch.
        state_d = state_q;
        seg_d   = seg_q;
        entry_d = entry_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        enter_d = 1'b0;

        if (is_multi) begin
            err_d = 1'b1;
        end else if (is_single) begin
            valid_d = 1'b1;
            code_d  = code;
            if (MODE == 0) begin
                seg_d      = '0;
                seg_d[7:0] = bcd;
            end else if (code <= KEY_ZERO) begin
                if (state_q != ST_FULL) begin
                    seg_d   = {seg_q[SEG_W-5:0], digit};
                    cnt_d   = cnt_q + 4'd1;
                    state_d = (cnt_q + 4'd1 == 4'(DIGITS)) ? ST_FULL : ST_PARTIAL;
                end
            end else if (code == KEY_BKSP) begin
                if (state_q != ST_EMPTY) begin
                    seg_d   = {4'h0, seg_q[SEG_W-1:4]};
                    cnt_d   = cnt_q - 4'd1;
                    state_d = (cnt_q == 4'd1) ? ST_EMPTY : ST_PARTIAL;
                end
            end else if (code == KEY_CLEAR) begin
                seg_d   = '0;
                cnt_d   = 4'd0;
                state_d = ST_EMPTY;
            end else if (code == KEY_ENTER) begin
                entry_d = seg_q;
                enter_d = 1'b1;
                seg_d   = '0;
                cnt_d   = 4'd0;
                state_d = ST_EMPTY;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            seg_q   <= '0;
            entry_q <= '0;
            cnt_q   <= 4'd0;
            code_q  <= 5'd0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            enter_q <= 1'b0;
        end else begin
            state_q <= state_d;
            seg_q   <= seg_d;
            entry_q <= entry_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            enter_q <= enter_d;
        end
    end

    assign bus.seg_data    = seg_q;
    assign bus.digit_cnt   = cnt_q;
    assign bus.key_code    = code_q;
    assign bus.key_valid   = valid_q;
    assign bus.multi_err   = err_q;
    assign bus.enter_pulse = enter_q;
    assign bus.entry_value = entry_q;
endmodule

// File: tb/tb_key_entry_decode.sv
// Directed bench: a MODE 1 and a MODE 0 decoder share one key stimulus and
// are compared against a hand-computed vector table plus an entry-hold sequence.
module tb_key_entry_decode;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    key_entry_decode_if #(.NUM_KEYS(16), .DIGITS(4)) if1 ();
    key_entry_decode_if #(.NUM_KEYS(16), .DIGITS(4)) if0 ();

    key_entry_decode #(.NUM_KEYS(16), .DIGITS(4), .MODE(1)) u_mode1 (
        .clk(clk), .rst_n(rst_n), .bus(if1)
    );
    key_entry_decode #(.NUM_KEYS(16), .DIGITS(4), .MODE(0)) u_mode0 (
        .clk(clk), .rst_n(rst_n), .bus(if0)
    );

    typedef struct {
        logic        rst;
        logic [15:0] key;
        logic [15:0] seg;
        logic [3:0]  cnt;
        logic [4:0]  code;
        logic        valid;
        logic        err;
        logic        enter;
        logic [15:0] entry;
        logic [15:0] seg0;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] kc(input int c);
        logic [15:0] one = 16'd1;
        return one << (c - 1);
    endfunction

    task automatic add(input logic rst, input logic [15:0] key, input logic [15:0] seg,
                       input logic [3:0] cnt, input logic [4:0] code, input logic valid,
                       input logic err, input logic enter, input logic [15:0] entry,
                       input logic [15:0] seg0);
        vec_t v;
        v.rst = rst; v.key = key; v.seg = seg; v.cnt = cnt; v.code = code;
        v.valid = valid; v.err = err; v.enter = enter; v.entry = entry; v.seg0 = seg0;
        vecs.push_back(v);
    endtask

    task automatic apply(input logic rst, input logic [15:0] key);
        rst_n         = rst;
        if1.key_pulse = key;
        if0.key_pulse = key;
        @(posedge clk);
        #1;
    endtask

    initial begin
        if1.key_pulse = '0;
        if0.key_pulse = '0;

        //   rst key        seg       cnt code  v  e  ent entry     seg0
        add(0, 16'h0,     16'h0000, 0, 0,  0, 0, 0, 16'h0000, 16'h0000);
        add(1, 16'h0,     16'h0000, 0, 0,  0, 0, 0, 16'h0000, 16'h0000);
        add(1, kc(11),    16'h0000, 0, 11, 1, 0, 0, 16'h0000, 16'h0011);
        add(1, kc(1),     16'h0001, 1, 1,  1, 0, 0, 16'h0000, 16'h0001);
        add(1, kc(2),     16'h0012, 2, 2,  1, 0, 0, 16'h0000, 16'h0002);
        add(1, 16'h0005,  16'h0012, 2, 2,  0, 1, 0, 16'h0000, 16'h0002);
        add(1, 16'h0,     16'h0012, 2, 2,  0, 0, 0, 16'h0000, 16'h0002);
        add(1, kc(12),    16'h0000, 0, 12, 1, 0, 0, 16'h0000, 16'h0012);
        add(1, kc(1),     16'h0001, 1, 1,  1, 0, 0, 16'h0000, 16'h0001);
        add(1, kc(2),     16'h0012, 2, 2,  1, 0, 0, 16'h0000, 16'h0002);
        add(1, kc(3),     16'h0123, 3, 3,  1, 0, 0, 16'h0000, 16'h0003);
        add(1, kc(4),     16'h1234, 4, 4,  1, 0, 0, 16'h0000, 16'h0004);
        add(1, kc(5),     16'h1234, 4, 5,  1, 0, 0, 16'h0000, 16'h0005);
        add(1, kc(11),    16'h0123, 3, 11, 1, 0, 0, 16'h0000, 16'h0011);
        add(1, kc(6),     16'h1236, 4, 6,  1, 0, 0, 16'h0000, 16'h0006);
        add(1, kc(13),    16'h0000, 0, 13, 1, 0, 1, 16'h1236, 16'h0013);
        add(1, 16'h0,     16'h0000, 0, 13, 0, 0, 0, 16'h1236, 16'h0013);
        add(1, kc(7),     16'h0007, 1, 7,  1, 0, 0, 16'h1236, 16'h0007);
        add(1, kc(10),    16'h0070, 2, 10, 1, 0, 0, 16'h1236, 16'h0010);
        add(1, kc(11),    16'h0007, 1, 11, 1, 0, 0, 16'h1236, 16'h0011);
        add(1, kc(3),     16'h0073, 2, 3,  1, 0, 0, 16'h1236, 16'h0003);
        add(1, kc(13),    16'h0000, 0, 13, 1, 0, 1, 16'h0073, 16'h0013);
        add(1, kc(13),    16'h0000, 0, 13, 1, 0, 1, 16'h0000, 16'h0013);
        add(1, kc(14),    16'h0000, 0, 14, 1, 0, 0, 16'h0000, 16'h0014);
        add(1, kc(10),    16'h0000, 1, 10, 1, 0, 0, 16'h0000, 16'h0010);
        add(1, kc(16),    16'h0000, 1, 16, 1, 0, 0, 16'h0000, 16'h0016);
        add(1, kc(9),     16'h0009, 2, 9,  1, 0, 0, 16'h0000, 16'h0009);
        add(0, kc(5),     16'h0000, 0, 0,  0, 0, 0, 16'h0000, 16'h0000);
        add(1, 16'h0,     16'h0000, 0, 0,  0, 0, 0, 16'h0000, 16'h0000);
        add(1, kc(4),     16'h0004, 1, 4,  1, 0, 0, 16'h0000, 16'h0004);
        add(1, kc(11),    16'h0000, 0, 11, 1, 0, 0, 16'h0000, 16'h0011);
        add(1, kc(11),    16'h0000, 0, 11, 1, 0, 0, 16'h0000, 16'h0011);

        @(negedge clk);
        foreach (vecs[i]) begin
            apply(vecs[i].rst, vecs[i].key);
            check($sformatf("v%0d seg_data",    i), 32'(if1.seg_data),    32'(vecs[i].seg));
            check($sformatf("v%0d digit_cnt",   i), 32'(if1.digit_cnt),   32'(vecs[i].cnt));
            check($sformatf("v%0d key_code",    i), 32'(if1.key_code),    32'(vecs[i].code));
            check($sformatf("v%0d key_valid",   i), 32'(if1.key_valid),   32'(vecs[i].valid));
            check($sformatf("v%0d multi_err",   i), 32'(if1.multi_err),   32'(vecs[i].err));
            check($sformatf("v%0d enter_pulse", i), 32'(if1.enter_pulse), 32'(vecs[i].enter));
            check($sformatf("v%0d entry_value", i), 32'(if1.entry_value), 32'(vecs[i].entry));
            check($sformatf("v%0d m0 seg_data", i), 32'(if0.seg_data),    32'(vecs[i].seg0));
            check($sformatf("v%0d m0 key_code", i), 32'(if0.key_code),    32'(vecs[i].code));
            check($sformatf("v%0d m0 key_valid",i), 32'(if0.key_valid),   32'(vecs[i].valid));
            check($sformatf("v%0d m0 multi_err",i), 32'(if0.multi_err),   32'(vecs[i].err));
            check($sformatf("v%0d m0 digit_cnt",i), 32'(if0.digit_cnt),   32'd0);
            check($sformatf("v%0d m0 enter",    i), 32'(if0.enter_pulse), 32'd0);
            check($sformatf("v%0d m0 entry",    i), 32'(if0.entry_value), 32'd0);
        end

        // Captured entry must survive CLEAR and idle cycles until the next ENTER.
        apply(1, kc(9));
        apply(1, kc(8));
        apply(1, kc(13));
        check("hold enter_pulse", 32'(if1.enter_pulse), 32'd1);
        check("hold capture",     32'(if1.entry_value), 32'h0098);
        apply(1, kc(2));
        apply(1, kc(12));
        check("hold clear seg", 32'(if1.seg_data), 32'h0000);
        for (int c = 0; c < 3; c++) begin
            apply(1, 16'h0);
            check($sformatf("hold idle%0d entry", c), 32'(if1.entry_value), 32'h0098);
            check($sformatf("hold idle%0d enter", c), 32'(if1.enter_pulse), 32'd0);
        end
        apply(1, kc(1));
        apply(0, 16'h0);
        check("reset entry", 32'(if1.entry_value), 32'h0000);
        check("reset seg",   32'(if1.seg_data),    32'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
